trap_arbiter: RTL and testbench
===============================

# trap_arbiter

Arbitrates synchronous exceptions and the three machine-level interrupt sources (software, timer, external) into one trap request for the exception unit. It owns the `mip`/`mie` pending and enable state, applies `mstatus.MIE` gating and fixed priority, and holds a latched cause stable across a valid/ready handshake. It tracks the in-handler period until `mret`. It sits between the WB-stage exception flags and the exception unit's trap-entry sequencer.

## Interface
Parameters:
- `XLEN`, 32, cause/data width
- `EXT_EDGE`, 1, 1: external interrupt is captured on its rising edge (sticky pending); 0: level-sensitive

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  core clock
- `rst`  in  1  synchronous active-high reset
- `irq_sw`, `irq_timer`, `irq_ext`  in  1 each  raw interrupt lines
- `illegal_inst`, `ecall_m`, `l_access_fault`, `s_access_fault`  in  1 each  WB-stage exception flags
- `mstatus_mie`  in  1  global interrupt enable, from the CSR file
- `mie_we`  in  1  write strobe for `mie`
- `mie_wdata`  in  XLEN  `mie` write data; only bits 3, 7 and 11 are stored
- `mret`  in  1  mret retiring in WB
- `trap_valid`  out  1  trap request to the exception unit
- `trap_ready`  in  1  the exception unit accepts the trap
- `trap_cause`  out  XLEN  `mcause` value; bit 31 marks an interrupt
- `hold_pipe`  out  1  freezes IF through MEM while a request is pending
- `in_handler`  out  1  a trap was accepted and `mret` has not yet retired
- `mip_out`, `mie_out`  out  XLEN  read-back values; only bits 3, 7 and 11 can be non-zero

## Operation
- Pending (`mip`) bits:
  - MSIP[3] and MTIP[7] are registered copies of `irq_sw` and `irq_timer`.
  - MEIP[11] follows `EXT_EDGE`. With `EXT_EDGE`=1 it is set on a 0→1 edge of `irq_ext` and cleared on the handshake that takes that interrupt. If set and clear happen in the same cycle, set wins.
- `mie`: written when `mie_we` is high. Bits other than 3, 7 and 11 read 0.
- Interrupt eligibility: `mip & mie` is non-zero and `mstatus_mie`=1.
- Priority, highest first:
  - Synchronous exceptions always beat interrupts: illegal (cause 2) > ecall (11) > load fault (5) > store fault (7).
  - Among interrupts: MEI (0x8000000B) > MSI (0x80000003) > MTI (0x80000007).
- FSM states IDLE, REQ, HANDLER:
  - IDLE → REQ when any exception flag is high or an interrupt is eligible. The winning cause is latched.
  - REQ: `trap_valid`=1 and `hold_pipe`=1. `trap_cause` is stable and cannot be re-arbitrated, even if the line drops or a higher-priority event arrives. On `trap_valid & trap_ready` → HANDLER.
  - HANDLER: `in_handler`=1 and interrupts are ignored.
    - A synchronous exception in HANDLER → REQ (nested trap).
    - `mret` → IDLE.
    - If an exception and `mret` arrive in the same cycle, the exception wins.
  - `mret` seen in IDLE or REQ is ignored.
- Reset values:
  - State IDLE.
  - `trap_valid`, `hold_pipe`, `in_handler` = 0.
  - `trap_cause`, `mip`, `mie` = 0.
  - The irq edge-detect history is cleared to 0.
- Reset mid-operation: reset in REQ or HANDLER drops the request immediately and loses pending MEIP.

## Timing
- `trap_valid`, `trap_cause`, `hold_pipe` and `in_handler` are registered: outputs are driven from the FSM state and the latched cause.
- Exception flag high in cycle N (IDLE) → `trap_valid` high in N+1.
- Interrupt line high in cycle N → `mip` set at edge N+1 → `trap_valid` high in N+2.
- Handshake accepted in cycle M → `in_handler`=1 and `trap_valid`=0 in M+1.
- For an accepted MEI, MEIP reads 0 in M+1.
- `mret` in cycle K (HANDLER) → state IDLE in K+1. A still-eligible interrupt raises `trap_valid` in K+2.
- `mie` write in cycle N is visible to arbitration from N+1.
- Back-to-back traps: minimum spacing from one accepted handshake to the next `trap_valid` is 2 cycles.

## Structure
- Shared package `trap_pkg`:
  - cause constants: `CAUSE_ILLEGAL`=2, `CAUSE_LFAULT`=5, `CAUSE_SFAULT`=7, `CAUSE_ECALL_M`=11, `CAUSE_MSI`, `CAUSE_MTI`, `CAUSE_MEI` with bit 31 set
  - `mip`/`mie` bit indices 3, 7 and 11
  - FSM state encoding
- One sub-module, `trap_prio_enc`: a combinational priority encoder taking exception flags and `mip & mie & {3{mstatus_mie}}`, producing `any` and `cause`. It is reused by the debug unit.

## Test plan
- `illegal_inst`=1 for one cycle in IDLE, `trap_ready` tied 1 → `trap_valid` exactly one cycle later with `trap_cause`=2, `in_handler`=1 the following cycle.
- `mie`=0x888, `mstatus_mie`=1, `irq_timer` and `irq_ext` rise together → `trap_cause`=0x8000000B. After `mret` with `irq_timer` still high → second trap with cause 0x80000007.
- `trap_ready` held 0 for 5 cycles while `ecall_m` pulses, then `irq_ext` rises → `trap_cause` stays 11 and `hold_pipe` stays 1 throughout. Acceptance on cycle 6.
- `EXT_EDGE`=1: `irq_ext` pulses for 1 cycle with `mstatus_mie`=0 → MEIP stays 1 in `mip_out` (0x800). Set `mstatus_mie`=1 → trap taken, then `mip_out`=0.
- In HANDLER, assert `l_access_fault` and `mret` in the same cycle → REQ with cause 5 and `in_handler` cleared. An eligible MTI during HANDLER produces no request.
- Assert `rst` for one cycle while in REQ → next cycle all outputs 0, state IDLE, `mie_out`=0.

Source files
------------

// File: rtl/trap_pkg.sv
// Shared definitions for trap arbitration: mcause values, mip/mie bit positions
// and the arbiter FSM encoding.
package trap_pkg;

    localparam logic [31:0] CAUSE_ILLEGAL = 32'd2;
    localparam logic [31:0] CAUSE_LFAULT  = 32'd5;
    localparam logic [31:0] CAUSE_SFAULT  = 32'd7;
    localparam logic [31:0] CAUSE_ECALL_M = 32'd11;
    localparam logic [31:0] CAUSE_MSI     = 32'h8000_0003;
    localparam logic [31:0] CAUSE_MTI     = 32'h8000_0007;
    localparam logic [31:0] CAUSE_MEI     = 32'h8000_000B;

    localparam int MSIP_BIT = 3;
    localparam int MTIP_BIT = 7;
    localparam int MEIP_BIT = 11;

    // Compact 3-bit interrupt vector ordering used between arbiter and encoder
    localparam int IRQ_SW    = 0;
    localparam int IRQ_TIMER = 1;
    localparam int IRQ_EXT   = 2;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_HANDLER = 2'd2;

endpackage

// File: rtl/trap_prio_enc.sv
// Fixed-priority trap encoder: synchronous exceptions first, then MEI > MSI > MTI.
// Purely combinational so the debug unit can reuse it.
module trap_prio_enc
    import trap_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            illegal_inst,
    input  logic            ecall_m,
    input  logic            l_access_fault,
    input  logic            s_access_fault,
    input  logic [2:0]      irq_act,
    output logic            any,
    output logic [XLEN-1:0] cause
);

    always_comb begin
        any   = 1'b1;
        cause = '0;
        if (illegal_inst)            cause = XLEN'(CAUSE_ILLEGAL);
        else if (ecall_m)            cause = XLEN'(CAUSE_ECALL_M);
        else if (l_access_fault)     cause = XLEN'(CAUSE_LFAULT);
        else if (s_access_fault)     cause = XLEN'(CAUSE_SFAULT);
        else if (irq_act[IRQ_EXT])   cause = XLEN'(CAUSE_MEI);
        else if (irq_act[IRQ_SW])    cause = XLEN'(CAUSE_MSI);
        else if (irq_act[IRQ_TIMER]) cause = XLEN'(CAUSE_MTI);
        else                         any   = 1'b0;
    end

endmodule

// File: rtl/trap_arbiter.sv
// Merges WB exceptions and machine interrupts into one latched trap request,
// owns mip/mie, and tracks the in-handler window until mret.
module trap_arbiter
    import trap_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter bit EXT_EDGE = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            irq_sw,
    input  logic            irq_timer,
    input  logic            irq_ext,
    input  logic            illegal_inst,
    input  logic            ecall_m,
    input  logic            l_access_fault,
    input  logic            s_access_fault,
    input  logic            mstatus_mie,
    input  logic            mie_we,
    input  logic [XLEN-1:0] mie_wdata,
    input  logic            mret,
    output logic            trap_valid,
    input  logic            trap_ready,
    output logic [XLEN-1:0] trap_cause,
    output logic            hold_pipe,
    output logic            in_handler,
    output logic [XLEN-1:0] mip_out,
    output logic [XLEN-1:0] mie_out
);

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] cause_q, cause_d;
    logic            msip_q, msip_d;
    logic            mtip_q, mtip_d;
    logic            meip_q, meip_d;
    logic            ext_prev_q, ext_prev_d;
    logic [2:0]      mie_q, mie_d;

    logic            enc_any;
    logic [XLEN-1:0] enc_cause;
    logic [2:0]      irq_act;
    logic            handshake;
    logic            unused_wdata;

    assign unused_wdata = ^mie_wdata;
    assign handshake    = (state_q == ST_REQ) && trap_ready;

    // Interrupts only compete from IDLE; in HANDLER only exceptions may nest.
    assign irq_act = (state_q == ST_IDLE)
                   ? ({meip_q, mtip_q, msip_q} & mie_q & {3{mstatus_mie}})
                   : 3'b000;

    trap_prio_enc #(.XLEN(XLEN)) u_prio_enc (
        .illegal_inst   (illegal_inst),
        .ecall_m        (ecall_m),
        .l_access_fault (l_access_fault),
        .s_access_fault (s_access_fault),
        .irq_act        (irq_act),
        .any            (enc_any),
        .cause          (enc_cause)
    );

    always_comb begin
        msip_d     = irq_sw;
        mtip_d     = irq_timer;
        ext_prev_d = irq_ext;
        if (EXT_EDGE) begin
            // A new rising edge in the same cycle as the clearing handshake keeps MEIP set
            meip_d = (irq_ext && !ext_prev_q)
                   || (meip_q && !(handshake && cause_q == XLEN'(CAUSE_MEI)));
        end else begin
            meip_d = irq_ext;
        end
        mie_d = mie_we ? {mie_wdata[MEIP_BIT], mie_wdata[MTIP_BIT], mie_wdata[MSIP_BIT]}
                       : mie_q;
    end

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        case (state_q)
            ST_IDLE: begin
                if (enc_any) begin
                    state_d = ST_REQ;
                    cause_d = enc_cause;
                end
            end
            ST_REQ: begin
                if (trap_ready) state_d = ST_HANDLER;
            end
            ST_HANDLER: begin
                if (enc_any) begin
                    state_d = ST_REQ;
                    cause_d = enc_cause;
                end else if (mret) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cause_q    <= '0;
            msip_q     <= 1'b0;
            mtip_q     <= 1'b0;
            meip_q     <= 1'b0;
            ext_prev_q <= 1'b0;
            mie_q      <= 3'b000;
        end else begin
            state_q    <= state_d;
            cause_q    <= cause_d;
            msip_q     <= msip_d;
            mtip_q     <= mtip_d;
            meip_q     <= meip_d;
            ext_prev_q <= ext_prev_d;
            mie_q      <= mie_d;
        end
    end

    assign trap_valid = (state_q == ST_REQ);
    assign hold_pipe  = (state_q == ST_REQ);
    assign in_handler = (state_q == ST_HANDLER);
    assign trap_cause = cause_q;

    always_comb begin
        mip_out           = '0;
        mip_out[MSIP_BIT] = msip_q;
        mip_out[MTIP_BIT] = mtip_q;
        mip_out[MEIP_BIT] = meip_q;
        mie_out           = '0;
        mie_out[MSIP_BIT] = mie_q[IRQ_SW];
        mie_out[MTIP_BIT] = mie_q[IRQ_TIMER];
        mie_out[MEIP_BIT] = mie_q[IRQ_EXT];
    end

endmodule

// File: tb/tb_trap_arbiter.sv
// Directed bench for trap_arbiter: handshake timing, priority, MEIP edge capture,
// nested exceptions and mid-request reset, each against hand-computed values.
module tb_trap_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        irq_sw, irq_timer, irq_ext;
    logic        illegal_inst, ecall_m, l_access_fault, s_access_fault;
    logic        mstatus_mie, mie_we, mret, trap_ready;
    logic [31:0] mie_wdata;
    logic        trap_valid, hold_pipe, in_handler;
    logic [31:0] trap_cause, mip_out, mie_out;

    int checks = 0;
    int errors = 0;

    trap_arbiter #(.XLEN(32), .EXT_EDGE(1'b1)) dut (
        .clk            (clk),
        .rst            (rst),
        .irq_sw         (irq_sw),
        .irq_timer      (irq_timer),
        .irq_ext        (irq_ext),
        .illegal_inst   (illegal_inst),
        .ecall_m        (ecall_m),
        .l_access_fault (l_access_fault),
        .s_access_fault (s_access_fault),
        .mstatus_mie    (mstatus_mie),
        .mie_we         (mie_we),
        .mie_wdata      (mie_wdata),
        .mret           (mret),
        .trap_valid     (trap_valid),
        .trap_ready     (trap_ready),
        .trap_cause     (trap_cause),
        .hold_pipe      (hold_pipe),
        .in_handler     (in_handler),
        .mip_out        (mip_out),
        .mie_out        (mie_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [3:0]  flag_vec [5] = '{4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0110};
    logic [31:0] flag_exp [5] = '{32'd2, 32'd11, 32'd5, 32'd7, 32'd11};

    initial begin
        rst = 1'b1;
        {irq_sw, irq_timer, irq_ext} = 3'b000;
        {illegal_inst, ecall_m, l_access_fault, s_access_fault} = 4'b0000;
        mstatus_mie = 1'b0; mie_we = 1'b0; mie_wdata = '0; mret = 1'b0; trap_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        check("rst_valid", {31'd0, trap_valid}, 32'd0);
        check("rst_hold", {31'd0, hold_pipe}, 32'd0);
        check("rst_inh", {31'd0, in_handler}, 32'd0);
        check("rst_cause", trap_cause, 32'd0);
        check("rst_mip", mip_out, 32'd0);
        check("rst_mie", mie_out, 32'd0);

        // Illegal instruction, ready tied high
        trap_ready = 1'b1;
        illegal_inst = 1'b1;
        check("ill_pre_valid", {31'd0, trap_valid}, 32'd0);
        step();
        illegal_inst = 1'b0;
        check("ill_valid", {31'd0, trap_valid}, 32'd1);
        check("ill_cause", trap_cause, 32'd2);
        check("ill_hold", {31'd0, hold_pipe}, 32'd1);
        step();
        check("ill_inh", {31'd0, in_handler}, 32'd1);
        check("ill_valid_low", {31'd0, trap_valid}, 32'd0);
        mret = 1'b1;
        step();
        mret = 1'b0;
        check("ill_mret_inh", {31'd0, in_handler}, 32'd0);

        // mie write masks to bits 3/7/11; MEI beats MTI, MTI follows after mret
        mie_we = 1'b1; mie_wdata = 32'hFFFF_FFFF;
        step();
        mie_we = 1'b0;
        check("mie_mask", mie_out, 32'h0000_0888);
        mstatus_mie = 1'b1;
        irq_timer = 1'b1; irq_ext = 1'b1;
        step();
        check("irq_mip", mip_out, 32'h0000_0880);
        check("irq_valid_n1", {31'd0, trap_valid}, 32'd0);
        step();
        check("mei_valid", {31'd0, trap_valid}, 32'd1);
        check("mei_cause", trap_cause, 32'h8000_000B);
        step();
        check("mei_inh", {31'd0, in_handler}, 32'd1);
        check("mei_cleared", mip_out, 32'h0000_0080);
        step();
        check("hdl_mti_ignored", {31'd0, trap_valid}, 32'd0);
        mret = 1'b1;
        step();
        mret = 1'b0;
        check("mret_idle_valid", {31'd0, trap_valid}, 32'd0);
        check("mret_idle_inh", {31'd0, in_handler}, 32'd0);
        step();
        check("mti_valid", {31'd0, trap_valid}, 32'd1);
        check("mti_cause", trap_cause, 32'h8000_0007);
        step();
        irq_timer = 1'b0; irq_ext = 1'b0; mret = 1'b1;
        step();
        mret = 1'b0;
        step();
        check("quiet_valid", {31'd0, trap_valid}, 32'd0);

        // Stalled request keeps its cause while a higher-priority interrupt arrives
        trap_ready = 1'b0;
        ecall_m = 1'b1;
        step();
        ecall_m = 1'b0;
        check("stall_valid", {31'd0, trap_valid}, 32'd1);
        check("stall_cause0", trap_cause, 32'd11);
        for (int i = 0; i < 4; i++) begin
            if (i == 1) irq_ext = 1'b1;
            step();
            check("stall_cause", trap_cause, 32'd11);
            check("stall_hold", {31'd0, hold_pipe}, 32'd1);
        end
        trap_ready = 1'b1;
        step();
        check("stall_acc_inh", {31'd0, in_handler}, 32'd1);
        check("stall_meip_kept", mip_out, 32'h0000_0800);
        mret = 1'b1;
        step();
        mret = 1'b0;
        step();
        check("pend_mei_cause", trap_cause, 32'h8000_000B);
        step();
        check("pend_mei_clr", mip_out, 32'd0);
        irq_ext = 1'b0; mret = 1'b1;
        step();
        mret = 1'b0;

        // Sticky MEIP while globally disabled
        mstatus_mie = 1'b0;
        irq_ext = 1'b1;
        step();
        irq_ext = 1'b0;
        step();
        check("sticky_mip", mip_out, 32'h0000_0800);
        check("sticky_novalid", {31'd0, trap_valid}, 32'd0);
        step();
        check("sticky_novalid2", {31'd0, trap_valid}, 32'd0);
        mstatus_mie = 1'b1;
        step();
        check("sticky_valid", {31'd0, trap_valid}, 32'd1);
        check("sticky_cause", trap_cause, 32'h8000_000B);
        step();
        check("sticky_clr", mip_out, 32'd0);
        check("sticky_inh", {31'd0, in_handler}, 32'd1);

        // In HANDLER: eligible MTI ignored; fault beats mret
        irq_timer = 1'b1;
        step(); step();
        check("hdl_no_req", {31'd0, trap_valid}, 32'd0);
        check("hdl_still_inh", {31'd0, in_handler}, 32'd1);
        l_access_fault = 1'b1; mret = 1'b1; trap_ready = 1'b0;
        step();
        l_access_fault = 1'b0; mret = 1'b0;
        check("nest_valid", {31'd0, trap_valid}, 32'd1);
        check("nest_cause", trap_cause, 32'd5);
        check("nest_inh", {31'd0, in_handler}, 32'd0);

        // Reset while REQ
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mrst_valid", {31'd0, trap_valid}, 32'd0);
        check("mrst_hold", {31'd0, hold_pipe}, 32'd0);
        check("mrst_inh", {31'd0, in_handler}, 32'd0);
        check("mrst_cause", trap_cause, 32'd0);
        check("mrst_mie", mie_out, 32'd0);
        check("mrst_mip", mip_out, 32'd0);
        irq_timer = 1'b0;
        step();
        check("mrst_idle", {31'd0, trap_valid}, 32'd0);

        // Exception priority table
        trap_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            {illegal_inst, ecall_m, l_access_fault, s_access_fault} = flag_vec[i];
            step();
            {illegal_inst, ecall_m, l_access_fault, s_access_fault} = 4'b0000;
            check("prio_exc", trap_cause, flag_exp[i]);
            step();
            check("prio_inh", {31'd0, in_handler}, 32'd1);
            mret = 1'b1;
            step();
            mret = 1'b0;
        end

        // MSI beats MTI
        mie_we = 1'b1; mie_wdata = 32'h0000_0888;
        irq_sw = 1'b1; irq_timer = 1'b1;
        step();
        mie_we = 1'b0;
        step();
        check("msi_over_mti", trap_cause, 32'h8000_0003);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
